// File: rtl/ps2_host_tx_if.sv
// ---------------------------------------------------------------------------
// ps2_host_tx_if
//   Bundle between the core / PS/2 pads and the host-to-device transmitter.
//   Signals:
//     tx_data[7:0]   command byte, sampled when a start is accepted
//     tx_start       one-cycle request, honoured only while the transmitter is idle
//     busy           high from accepted start until the done pulse
//     done           one-cycle end-of-transfer pulse
//     error          one-cycle pulse with done: nack or timeout
//     ps2_clk_in     PS/2 clock line level (asynchronous)
//     ps2_data_in    PS/2 data line level (asynchronous)
//     ps2_clk_out    0 = pull clock low, 1 = release
//     ps2_data_out   0 = pull data low, 1 = release
//   master: core/pad side driving the request and line levels.
//   slave : the transmitter.
// ---------------------------------------------------------------------------
interface ps2_host_tx_if;
  logic [7:0] tx_data;
  logic       tx_start;
  logic       busy;
  logic       done;
  logic       error;
  logic       ps2_clk_in;
  logic       ps2_data_in;
  logic       ps2_clk_out;
  logic       ps2_data_out;

  modport master (
    output tx_data, tx_start, ps2_clk_in, ps2_data_in,
    input  busy, done, error, ps2_clk_out, ps2_data_out
  );

  modport slave (
    input  tx_data, tx_start, ps2_clk_in, ps2_data_in,
    output busy, done, error, ps2_clk_out, ps2_data_out
  );
endinterface

// File: rtl/ps2_host_tx.sv
// ---------------------------------------------------------------------------
// ps2_host_tx
//   PS/2 host-to-device transmitter. Sends one command byte to the mouse:
//   clock inhibit, request-to-send, device-clocked serialisation (LSB first,
//   odd parity, stop bit) and ack check, with an overall timeout.
//   Ports:
//     i_clk        system clock
//     i_reset_n    synchronous reset, active low
//     io_tx        ps2_host_tx_if.slave (request/status and PS/2 line levels)
//   Parameters:
//     INHIBIT_CYCLES  clk cycles the clock line is held low before the request
//     TIMEOUT_CYCLES  clk cycles from clock release to completion before abort
//     TIMER_W         width of the shared inhibit/timeout counter
// ---------------------------------------------------------------------------
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 2200,
  parameter int TIMEOUT_CYCLES = 327680,
  parameter int TIMER_W        = 19
) (
  input  logic           i_clk,
  input  logic           i_reset_n,
  ps2_host_tx_if.slave   io_tx
);

  localparam logic [TIMER_W-1:0] INH_LAST = TIMER_W'(INHIBIT_CYCLES - 1);
  localparam logic [TIMER_W-1:0] TO_LAST  = TIMER_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_INHIBIT,
    S_REQ,
    S_RELEASE,
    S_ACK,
    S_WAIT_IDLE,
    S_DONE
  } state_t;

  state_t             r_state,  w_state_nxt;
  logic [TIMER_W-1:0] r_timer,  w_timer_nxt;
  logic [9:0]         r_shift,  w_shift_nxt;
  logic [3:0]         r_cnt,    w_cnt_nxt;
  logic               r_txd,    w_txd_nxt;   // data level driven while in RELEASE
  logic               r_err,    w_err_nxt;

  // line synchronisers; r_clk_d holds the previous synchronised clock level
  logic r_clk_s1, r_clk_s2, r_clk_d;
  logic r_dat_s1, r_dat_s2;

  logic               w_fall;
  logic [TIMER_W-1:0] w_timer_inc;
  logic               w_timeout;

  assign w_fall      = r_clk_d & ~r_clk_s2;
  // saturating increment so a stuck line can never wrap the timer back to 0
  assign w_timer_inc = (r_timer == {TIMER_W{1'b1}}) ? r_timer : r_timer + 1'b1;
  assign w_timeout   = (r_timer >= TO_LAST);

  // -------------------------------------------------------------------------
  // state register
  // -------------------------------------------------------------------------
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_state  <= S_IDLE;
      r_timer  <= '0;
      r_shift  <= '0;
      r_cnt    <= '0;
      r_txd    <= 1'b1;
      r_err    <= 1'b0;
      r_clk_s1 <= 1'b1;
      r_clk_s2 <= 1'b1;
      r_clk_d  <= 1'b1;
      r_dat_s1 <= 1'b1;
      r_dat_s2 <= 1'b1;
    end else begin
      r_state  <= w_state_nxt;
      r_timer  <= w_timer_nxt;
      r_shift  <= w_shift_nxt;
      r_cnt    <= w_cnt_nxt;
      r_txd    <= w_txd_nxt;
      r_err    <= w_err_nxt;
      r_clk_s1 <= io_tx.ps2_clk_in;
      r_clk_s2 <= r_clk_s1;
      r_clk_d  <= r_clk_s2;
      r_dat_s1 <= io_tx.ps2_data_in;
      r_dat_s2 <= r_dat_s1;
    end
  end

  // -------------------------------------------------------------------------
  // next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    w_timer_nxt = r_timer;
    w_shift_nxt = r_shift;
    w_cnt_nxt   = r_cnt;
    w_txd_nxt   = r_txd;
    w_err_nxt   = r_err;

    case (r_state)
      S_IDLE: begin
        if (io_tx.tx_start) begin
          w_state_nxt = S_INHIBIT;
          w_timer_nxt = '0;
          // stop, odd parity, data; shifted out LSB first
          w_shift_nxt = {1'b1, ~^io_tx.tx_data, io_tx.tx_data};
          w_cnt_nxt   = '0;
          w_txd_nxt   = 1'b0;
          w_err_nxt   = 1'b0;
        end
      end

      S_INHIBIT: begin
        if (r_timer == INH_LAST) w_state_nxt = S_REQ;
        else                     w_timer_nxt = w_timer_inc;
      end

      S_REQ: begin
        w_state_nxt = S_RELEASE;
        w_timer_nxt = '0;
        w_txd_nxt   = 1'b0;
      end

      S_RELEASE: begin
        if (w_timeout) begin
          w_state_nxt = S_DONE;
          w_err_nxt   = 1'b1;
        end else begin
          w_timer_nxt = w_timer_inc;
          // device has pulled clock low: present the next bit for its rising edge
          if (w_fall) begin
            w_txd_nxt   = r_shift[0];
            w_shift_nxt = {1'b0, r_shift[9:1]};
            w_cnt_nxt   = r_cnt + 1'b1;
            if (r_cnt == 4'd9) w_state_nxt = S_ACK;
          end
        end
      end

      S_ACK: begin
        if (w_timeout) begin
          w_state_nxt = S_DONE;
          w_err_nxt   = 1'b1;
        end else begin
          w_timer_nxt = w_timer_inc;
          if (w_fall) begin
            w_err_nxt   = r_dat_s2;       // device must hold data low to ack
            w_state_nxt = S_WAIT_IDLE;
          end
        end
      end

      S_WAIT_IDLE: begin
        if (w_timeout) begin
          w_state_nxt = S_DONE;
          w_err_nxt   = 1'b1;
        end else begin
          w_timer_nxt = w_timer_inc;
          if (r_clk_s2 && r_dat_s2) w_state_nxt = S_DONE;
        end
      end

      S_DONE: begin
        w_state_nxt = S_IDLE;
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // outputs, decoded from registered state only
  // -------------------------------------------------------------------------
  assign io_tx.busy         = (r_state != S_IDLE) && (r_state != S_DONE);
  assign io_tx.done         = (r_state == S_DONE);
  assign io_tx.error        = (r_state == S_DONE) && r_err;
  assign io_tx.ps2_clk_out  = !((r_state == S_INHIBIT) || (r_state == S_REQ));
  assign io_tx.ps2_data_out = (r_state == S_REQ)     ? 1'b0  :
                              (r_state == S_RELEASE) ? r_txd : 1'b1;

endmodule
